mem_cmd_queue: RTL

Request front-end that sits directly upstream of the 256x8 memory controller. It accepts host read/write requests over a valid/ready handshake and buffers them in order. It issues at most one command per cycle on the controller's rd_wr / rd_wr_valid / addr / wr_data pins, then captures the controller's registered read data into a response FIFO returned to the host with valid/ready.

---
 rtl/mem_ctrl_pkg.sv | 11 +
 rtl/mem_cmd_queue_if.sv | 27 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/mem_cmd_queue.sv | 103 ++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths and request record for the memory controller front-end.
package mem_ctrl_pkg;
    localparam int MEM_AW = 8;
    localparam int MEM_DW = 8;
    localparam int STAT_W = 16;
    typedef struct packed {
        logic              rd_wr;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/mem_cmd_queue_if.sv
// mem_cmd_queue_if: host request/response handshakes plus the controller command pins.
interface mem_cmd_queue_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_rd_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          mem_rd_wr;
    logic          mem_rd_wr_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    modport slave (
        input  req_valid, req_rd_wr, req_addr, req_wdata, rsp_ready, mem_rd_data,
        output req_ready, rsp_valid, rsp_data, mem_rd_wr, mem_rd_wr_valid, mem_addr, mem_wr_data
    );
    modport master (
        output req_valid, req_rd_wr, req_addr, req_wdata, rsp_ready, mem_rd_data,
        input  req_ready, rsp_valid, rsp_data, mem_rd_wr, mem_rd_wr_valid, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO with registered count; head reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage needs no reset: contents are only visible through a valid count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_ok);
            rd_ptr_q <= rd_ptr_q + PW'(pop_ok);
            count_q  <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/mem_cmd_queue.sv
// mem_cmd_queue: in-order request queue issuing one command per cycle to the 256x8 controller.
// Define MEM_CMD_QUEUE_STATS_EN to add saturating 16-bit read/write issue counters.
module mem_cmd_queue
    import mem_ctrl_pkg::*;
#(
    parameter int AW        = MEM_AW,
    parameter int DW        = MEM_DW,
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_cmd_queue_if.slave     bus
`ifdef MEM_CMD_QUEUE_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_rd_cnt,
    output logic [STAT_W-1:0]  stat_wr_cnt
`endif
);
    localparam int QCW = $clog2(REQ_DEPTH + 1);
    localparam int RCW = $clog2(RSP_DEPTH + 1);

    mem_req_t      req_in, req_head;
    logic          req_full, req_empty, rsp_full, rsp_empty;
    logic [QCW-1:0] req_count;
    logic [RCW-1:0] rsp_count;
    logic          req_push, rsp_pop, issue, issue_rd, capture;
    logic [1:0]    inflight_q, inflight_d, rd_pipe_q, rd_pipe_d;
    logic          mem_valid_q, mem_rd_wr_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wr_data_q;
    logic          unused_flags;

    assign req_in = '{rd_wr: bus.req_rd_wr, addr: MEM_AW'(bus.req_addr), wdata: MEM_DW'(bus.req_wdata)};

    sync_fifo #(.WIDTH($bits(mem_req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk(clk), .reset_n(reset_n), .push_i(req_push), .pop_i(issue),
        .data_i(req_in), .data_o(req_head), .full_o(req_full), .empty_o(req_empty), .count_o(req_count)
    );

    sync_fifo #(.WIDTH(DW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk(clk), .reset_n(reset_n), .push_i(capture), .pop_i(rsp_pop),
        .data_i(bus.mem_rd_data), .data_o(bus.rsp_data), .full_o(rsp_full), .empty_o(rsp_empty), .count_o(rsp_count)
    );

    // Reads need a response slot reserved against both stored and in-flight data; same-edge pops are not credited.
    always_comb begin
        req_push   = bus.req_valid && !req_full;
        rsp_pop    = bus.rsp_ready && !rsp_empty;
        issue      = !req_empty && (!req_head.rd_wr || (int'(rsp_count) + int'(inflight_q) < RSP_DEPTH));
        issue_rd   = issue && req_head.rd_wr;
        capture    = rd_pipe_q[1];
        rd_pipe_d  = {rd_pipe_q[0], issue_rd};
        inflight_d = inflight_q + {1'b0, issue_rd} - {1'b0, capture};
    end

    // Command register: address and data hold between issues; capture pipe tracks controller read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_valid_q   <= 1'b0;
            mem_rd_wr_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            rd_pipe_q     <= '0;
            inflight_q    <= '0;
        end else begin
            mem_valid_q <= issue;
            rd_pipe_q   <= rd_pipe_d;
            inflight_q  <= inflight_d;
            if (issue) begin
                mem_rd_wr_q   <= req_head.rd_wr;
                mem_addr_q    <= AW'(req_head.addr);
                mem_wr_data_q <= DW'(req_head.wdata);
            end
        end
    end

    assign bus.req_ready       = !req_full;
    assign bus.rsp_valid       = !rsp_empty;
    assign bus.mem_rd_wr_valid = mem_valid_q;
    assign bus.mem_rd_wr       = mem_rd_wr_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wr_data     = mem_wr_data_q;
    assign unused_flags        = ^{req_count, rsp_full};

`ifdef MEM_CMD_QUEUE_STATS_EN
    logic [STAT_W-1:0] stat_rd_q, stat_wr_q;

    // Issue counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            if (issue_rd && stat_rd_q != '1) stat_rd_q <= stat_rd_q + STAT_W'(1);
            if (issue && !req_head.rd_wr && stat_wr_q != '1) stat_wr_q <= stat_wr_q + STAT_W'(1);
        end
    end

    assign stat_rd_cnt = stat_rd_q;
    assign stat_wr_cnt = stat_wr_q;
`endif
endmodule
